// File: rtl/imem_fetch_unit_if.sv
// Fetch front-end port bundle: run/stall/redirect control in, BRAM read port, decode stream out.
// Latency: none, wires only.
// Backpressure: stall_i from decode is the only throttle; no ready/credit path toward the BRAM.
interface imem_fetch_unit_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              en_i;
    logic              stall_i;
    logic              redirect_i;
    logic [31:0]       redirect_pc_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_data_i;
    logic [31:0]       pc_o;
    logic [DATA_W-1:0] instr_o;
    logic              valid_o;
    logic              misalign_o;

    // Fetch unit side
    modport master (
        input  en_i, stall_i, redirect_i, redirect_pc_i, imem_data_i,
        output imem_addr_o, pc_o, instr_o, valid_o, misalign_o
    );

    // Control, BRAM and decode side
    modport slave (
        output en_i, stall_i, redirect_i, redirect_pc_i, imem_data_i,
        input  imem_addr_o, pc_o, instr_o, valid_o, misalign_o
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction fetch front-end driving a 1-cycle-latency BRAM and streaming (pc, instr, valid) to decode.
// Latency: first word valid one cycle after en_i is sampled; 1 word/cycle, one squashed slot per redirect.
// Backpressure: stall_i holds pc and BRAM address so the BRAM re-reads the word; no skid buffer.
module imem_fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    imem_fetch_unit_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, next_pc;
    logic              misalign_q, misalign_d;
    logic              valid;
    logic [DATA_W-1:0] instr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= next_pc;
            misalign_q <= misalign_d;
        end
    end

    // The word in a redirect cycle is wrong-path, so redirect squashes it combinationally.
    always_comb begin
        valid      = (state_q == RUN) && !bus.redirect_i;
        next_pc    = pc_q;
        state_d    = state_q;
        misalign_d = misalign_q;

        if (bus.redirect_i) begin
            next_pc = {bus.redirect_pc_i[31:2], 2'b00};
        end else if (valid && !bus.stall_i) begin
            next_pc = pc_q + 32'd4;
        end

        if (bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A redirect while idle only preloads the start address.
                if (!bus.redirect_i && bus.en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.en_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr           = bus.imem_data_i;
    assign bus.instr_o     = instr;
    assign bus.imem_addr_o = next_pc[ADDR_W+1:2];
    assign bus.pc_o        = pc_q;
    assign bus.valid_o     = valid;
    assign bus.misalign_o  = misalign_q;

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Instruction fetch front-end in the processor clock domain. It sits directly downstream of the JTAG-loadable instruction BRAM: it drives the BRAM read address and consumes the registered read data, which has 1-cycle latency. It delivers a stream of (pc, instruction, valid) words to decode, with stall, redirect and run-enable control. Run-enable is held low while the JTAG side is loading memory.

## Interface
- ADDR_W, 10: BRAM word-address width (memory depth 2^ADDR_W words).
- DATA_W, 32: instruction width.
- RESET_PC, 32'h0000_0000: first fetch byte address after reset.

- clk_i  in  1  processor clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  run enable; low = fetch idle.
- stall_i  in  1  decode not ready; hold current word.
- redirect_i  in  1  branch/jump redirect request.
- redirect_pc_i  in  32  redirect target byte address.
- imem_addr_o  out  ADDR_W  word address to BRAM read port.
- imem_data_i  in  DATA_W  BRAM read data (word addressed on previous edge).
- pc_o  out  32  byte address of instr_o.
- instr_o  out  DATA_W  fetched instruction (= imem_data_i).
- valid_o  out  1  instr_o/pc_o valid this cycle.
- misalign_o  out  1  sticky: a redirect target had bits [1:0] != 0.

## Operation
- Registers:
  - state_q ∈ {IDLE, RUN}
  - pc_q: byte address of the word currently on imem_data_i
  - misalign_q
- Outputs:
  - pc_o = pc_q
  - instr_o = imem_data_i
  - valid_o = (state_q==RUN) && !redirect_i
  - misalign_o = misalign_q
- next_pc selection, priority highest first:
  1. redirect_i → {redirect_pc_i[31:2],2'b00}
  2. state_q==RUN && valid_o && !stall_i → pc_q+4, modulo 2^32
  3. otherwise → pc_q
- imem_addr_o = next_pc[ADDR_W+1:2], combinational. Upper bits are ignored, so addresses wrap every 2^ADDR_W words.
- pc_q <= next_pc on every edge.
- FSM:
  - IDLE → RUN when en_i=1; pc_q is unchanged, so the word at pc_q is read on that edge.
  - RUN → IDLE when en_i=0. If the current word was accepted (valid_o && !stall_i), pc advances; otherwise pc holds. On re-enable, fetch resumes at the first unconsumed word.
  - redirect_i in IDLE loads pc_q and stays in IDLE; use this to set the start address.
  - redirect_i in RUN moves to RUN if en_i=1, else IDLE.
- Stall: pc_q and the BRAM address are held, so the BRAM re-reads the same word and instr_o stays stable. No skid buffer is needed.
- Redirect squash: the word present in the redirect cycle is wrong-path and valid_o is forced 0. Redirect overrides stall.
- misalign_q <= 1 on any cycle with redirect_i && redirect_pc_i[1:0]!=0. It is cleared only by rst_i.

## Timing
- Reset values:
  - state_q=IDLE, pc_q=RESET_PC, misalign_q=0.
  - Hence valid_o=0, pc_o=RESET_PC, misalign_o=0.
  - imem_addr_o=RESET_PC[ADDR_W+1:2].
  - instr_o follows BRAM data and is don't-care while valid_o=0.
  - All register values take effect immediately on rst_i assertion, independent of clk_i.
- Start latency: en_i high sampled at edge k → valid_o=1, pc_o=RESET_PC from cycle k+1.
- Throughput: 1 word/cycle while !stall_i.
- Redirect:
  - redirect_i in cycle n → valid_o=0 in cycle n.
  - Target word valid in cycle n+1, giving a penalty of 1 squashed slot.
- Stall: stall_i=1 in cycle n → identical pc_o/instr_o/valid_o in cycle n+1.
- Combinational paths: redirect_i/stall_i → imem_addr_o, and redirect_i → valid_o. Both must close timing in a single cycle.
- Reset mid-run: valid_o drops asynchronously. After release, behaviour is as from cold reset, including a new IDLE→RUN on en_i.

## Test plan
- Cold start:
  - Stimulus: BRAM words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193; RESET_PC=0; en_i raised after reset release.
  - Required response: valid_o rises one cycle later; pc_o = 0, 4, 8, 0xC on consecutive cycles, with the matching instr_o.
- Stall:
  - Stimulus: stall_i high for 3 cycles while pc_o=8.
  - Required response: pc_o=8, instr_o=0x00200113, valid_o=1 held for 4 cycles total; then pc_o=0xC.
- Redirect:
  - Stimulus: redirect_i with redirect_pc_i=0x40 while pc_o=4.
  - Required response: valid_o=0 that cycle; next cycle pc_o=0x40 with instr_o=mem[16]; redirect concurrent with stall_i gives the same result.
- Misaligned redirect:
  - Stimulus: redirect_pc_i=0x42.
  - Required response: next cycle pc_o=0x40 and misalign_o=1; misalign_o stays 1 over 10 further cycles and clears only on rst_i.
- Wrap:
  - Stimulus: ADDR_W=10, running through pc_q=0xFFC.
  - Required response: next pc_o=0x1000, imem_addr_o=0, instr_o=mem[0].
- Enable/reset interplay:
  - Stimulus: en_i dropped while stalled at pc 0x8, then re-raised.
  - Required response: valid_o=0 while idle; the first valid word after re-enable is pc 0x8.
  - Stimulus: rst_i pulsed between clock edges during RUN.
  - Required response: valid_o=0 and pc_o=RESET_PC immediately.
